cdc_ingress_arbiter: RTL and testbench

//  Round-robin packet arbiter that shares the cdc_noip ingress port (clk_a side) among NUM_REQ sources.

---
 rtl/cdc_ingress_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_cdc_ingress_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdc_ingress_arbiter
// Description : Round-robin packet arbiter sharing the cdc_noip ingress port
//               (clk_a side) among NUM_REQ sources. One grant per packet,
//               inter-packet gap, frame-length truncation, stall timeout,
//               packet counter and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_ingress_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 2,
  parameter int IPG       = 10,
  parameter int MAX_BYTES = 42,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk_a,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         src_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   src_data,
  input  logic [NUM_REQ-1:0]         src_last,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       data_valid_a,
  output logic [WIDTH-1:0]           data_a,
  output logic                       busy,
  output logic [15:0]                pkt_count,
  output logic                       err_len,
  output logic                       err_timeout,
  input  logic                       err_clr
);

  localparam int c_IDX_W = $clog2(NUM_REQ);
  localparam int c_BC_W  = $clog2(MAX_BYTES + 1);
  localparam int c_ST_W  = $clog2(TIMEOUT + 1);
  localparam int c_GAP_W = (IPG > 1) ? $clog2(IPG + 1) : 1;

  localparam logic [c_BC_W-1:0]  c_BYTE_END  = c_BC_W'(MAX_BYTES - 1);
  localparam logic [c_ST_W-1:0]  c_STALL_END = c_ST_W'(TIMEOUT - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_END   = c_GAP_W'((IPG > 0) ? IPG - 1 : 0);
  localparam logic [NUM_REQ-1:0] c_GRANT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SEND = 2'd1;
  localparam logic [1:0] c_GAP  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_IDX_W-1:0] r_last_grant;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_data_valid;
  logic [WIDTH-1:0]   r_data;
  logic [15:0]        r_pkt_count;
  logic               r_err_len;
  logic               r_err_timeout;
  logic [c_BC_W-1:0]  r_byte_cnt;
  logic [c_ST_W-1:0]  r_stall_cnt;
  logic [c_GAP_W-1:0] r_gap_cnt;

  logic               w_sel_found;
  logic [c_IDX_W-1:0] w_sel_idx;
  int                 w_cand;
  logic               w_start;
  logic               w_g_valid;
  logic               w_g_last;
  logic [WIDTH-1:0]   w_g_data;
  logic               w_fwd;
  logic               w_end_last;
  logic               w_trunc;
  logic               w_stall_abort;
  logic               w_pkt_end;
  logic               w_gap_done;
  logic               w_busy;

  // Round-robin pick: first requester scanning upward from the source after the last grant
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_sel_found) begin
        w_cand = int'(r_last_grant) + i;
        if (w_cand >= NUM_REQ) begin
          w_cand = w_cand - NUM_REQ;
        end
        if (req[c_IDX_W'(w_cand)]) begin
          w_sel_found = 1'b1;
          w_sel_idx   = c_IDX_W'(w_cand);
        end
      end
    end
  end

  // Select the granted source's byte lane; last_grant names the grantee while in SEND
  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_last_grant == c_IDX_W'(i)) begin
        w_g_valid = src_valid[i];
        w_g_last  = src_last[i];
        w_g_data  = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Packet-termination and gap-completion conditions shared by FSM and datapath
  always_comb begin
    w_start       = enable & w_sel_found;
    w_fwd         = (r_state == c_SEND) & w_g_valid;
    w_end_last    = w_fwd & w_g_last;
    w_trunc       = w_fwd & ~w_g_last & (r_byte_cnt == c_BYTE_END);
    w_stall_abort = (r_state == c_SEND) & ~w_g_valid & (r_stall_cnt == c_STALL_END);
    w_pkt_end     = w_end_last | w_trunc | w_stall_abort;
    w_gap_done    = (IPG == 0) ? 1'b1 : (r_gap_cnt == c_GAP_END);
  end

  // FSM state register
  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_start)    w_state_nxt = c_SEND;
      c_SEND:  if (w_pkt_end)  w_state_nxt = c_GAP;
      c_GAP:   if (w_gap_done) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_busy = (r_state != c_IDLE);
  end

  // Grant, byte forwarding, counters and sticky error flags
  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      r_last_grant  <= c_IDX_W'(NUM_REQ - 1);
      r_grant       <= '0;
      r_data_valid  <= 1'b0;
      r_data        <= '0;
      r_pkt_count   <= '0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_byte_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_data_valid  <= 1'b0;
      r_err_len     <= w_trunc | (r_err_len & ~err_clr);
      r_err_timeout <= w_stall_abort | (r_err_timeout & ~err_clr);
      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            r_grant      <= c_GRANT_LSB << w_sel_idx;
            r_last_grant <= w_sel_idx;
            r_byte_cnt   <= '0;
            r_stall_cnt  <= '0;
          end
        end
        c_SEND: begin
          if (w_g_valid) begin
            r_data_valid <= 1'b1;
            r_data       <= w_g_data;
            r_byte_cnt   <= r_byte_cnt + c_BC_W'(1);
            r_stall_cnt  <= '0;
          end else if (!w_stall_abort) begin
            r_stall_cnt  <= r_stall_cnt + c_ST_W'(1);
          end
          if (w_end_last || w_trunc) begin
            r_pkt_count <= r_pkt_count + 16'd1;
          end
          if (w_pkt_end) begin
            r_grant   <= '0;
            r_gap_cnt <= '0;
          end
        end
        c_GAP: begin
          r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
        end
        default: begin
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign data_valid_a = r_data_valid;
  assign data_a       = r_data;
  assign busy         = w_busy;
  assign pkt_count    = r_pkt_count;
  assign err_len      = r_err_len;
  assign err_timeout  = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cdc_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_ingress_arbiter
// Description : Directed, table-driven bench for cdc_ingress_arbiter with
//               hand-written sequences for arbitration, timeout, enable and
//               mid-packet reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_ingress_arbiter;

  localparam int NR = 2;
  localparam int W  = 8;

  logic            clk_a = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [NR-1:0]   req;
  logic [NR-1:0]   src_valid;
  logic [NR*W-1:0] src_data;
  logic [NR-1:0]   src_last;
  logic [NR-1:0]   grant;
  logic            data_valid_a;
  logic [W-1:0]    data_a;
  logic            busy;
  logic [15:0]     pkt_count;
  logic            err_len;
  logic            err_timeout;
  logic            err_clr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cdc_ingress_arbiter #(
    .WIDTH(W), .NUM_REQ(NR), .IPG(10), .MAX_BYTES(42), .TIMEOUT(64)
  ) dut (
    .clk_a(clk_a), .rst_n(rst_n), .enable(enable), .req(req),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .grant(grant), .data_valid_a(data_valid_a), .data_a(data_a), .busy(busy),
    .pkt_count(pkt_count), .err_len(err_len), .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  always #5 clk_a = ~clk_a;

  always @(posedge clk_a) cyc <= cyc + 1;

  // Grant must never have more than one bit set
  always @(negedge clk_a) begin
    checks++;
    if ($countones(grant) > 1) begin
      errors++;
      $display("FAIL grant_onehot actual=%b required=onehot_or_zero", grant);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(output logic [NR-1:0] g);
    int n = 0;
    while (grant == '0 && n < 200) begin
      @(negedge clk_a);
      n++;
    end
    g = grant;
    if (grant == '0) chk("grant_wait_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk_a);
      n++;
    end
    if (busy) chk("idle_wait_timeout", 32'(busy), 32'd0);
  endtask

  // Drive bytes while the source holds grant; every byte must appear one cycle later
  task automatic drive_bytes(input int src, input int n, input bit with_last,
                             input logic [7:0] base, output int sent,
                             output int t_first, output int t_last);
    int k = 0;
    t_first = -1;
    t_last  = -1;
    while (k < n && grant[src]) begin
      src_valid[src]          = 1'b1;
      src_data[src*W +: W]    = base + k[7:0];
      src_last[src]           = with_last && (k == n - 1);
      @(negedge clk_a);
      chk("fwd_valid", 32'(data_valid_a), 32'd1);
      chk("fwd_data", 32'(data_a), 32'(base + k[7:0]));
      if (k == 0) t_first = cyc;
      t_last = cyc;
      k++;
      src_valid[src] = 1'b0;
      src_last[src]  = 1'b0;
    end
    sent = k;
  endtask

  typedef struct {
    int         src;
    int         n;
    bit         last;
    logic [7:0] base;
    int         exp_sent;
    bit         exp_err_len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [NR-1:0] g;
    int sent, tf, tl, prev_last, cnt;
    logic [15:0] pc;

    vecs[0] = '{0, 42, 1'b1, 8'h01, 42, 1'b0};  // full-length packet with last
    vecs[1] = '{1,  1, 1'b1, 8'hA5,  1, 1'b0};  // single-byte packet
    vecs[2] = '{0, 50, 1'b0, 8'h40, 42, 1'b1};  // no last, truncated
    vecs[3] = '{1, 42, 1'b1, 8'h80, 42, 1'b0};  // last exactly on MAX_BYTES
    vecs[4] = '{0, 41, 1'b1, 8'h10, 41, 1'b0};  // one under the limit
    vecs[5] = '{1, 43, 1'b1, 8'hC0, 42, 1'b1};  // last arrives past the limit

    rst_n = 1'b0; enable = 1'b1; req = '0; src_valid = '0; src_data = '0;
    src_last = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk_a);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(data_valid_a), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt", 32'(pkt_count), 32'd0);
    chk("rst_errs", {30'd0, err_len, err_timeout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_a);
    chk("post_rst_grant", 32'(grant), 32'd0);

    // Table-driven packets
    for (int i = 0; i < 6; i++) begin
      pc = pkt_count;
      req[vecs[i].src] = 1'b1;
      wait_grant(g);
      chk("row_grant", 32'(g), 32'(1 << vecs[i].src));
      req[vecs[i].src] = 1'b0;
      drive_bytes(vecs[i].src, vecs[i].n, vecs[i].last, vecs[i].base, sent, tf, tl);
      chk("row_sent", 32'(sent), 32'(vecs[i].exp_sent));
      chk("row_err_len", 32'(err_len), 32'(vecs[i].exp_err_len));
      chk("row_err_timeout", 32'(err_timeout), 32'd0);
      chk("row_pkt", 32'(pkt_count), 32'(pc + 16'd1));
      wait_idle();
      if (vecs[i].exp_err_len) begin
        err_clr = 1'b1;
        @(negedge clk_a);
        err_clr = 1'b0;
        chk("err_len_clr", 32'(err_len), 32'd0);
      end
    end

    // Round-robin alternation with IPG spacing, both requests held
    pc = pkt_count;
    prev_last = 0;
    req = 2'b11;
    for (int p = 0; p < 4; p++) begin
      wait_grant(g);
      chk("rr_grant", 32'(g), (p % 2 == 0) ? 32'd1 : 32'd2);
      drive_bytes(g[1] ? 1 : 0, 42, 1'b1, 8'(p * 16), sent, tf, tl);
      chk("rr_sent", 32'(sent), 32'd42);
      if (p > 0) chk("ipg_spacing", 32'(tf - prev_last), 32'd12);
      prev_last = tl;
    end
    req = 2'b00;
    chk("rr_pkt", 32'(pkt_count), 32'(pc + 16'd4));
    wait_idle();

    // Stall timeout on src1, then src0 is served
    pc = pkt_count;
    req = 2'b10;
    wait_grant(g);
    chk("to_grant", 32'(g), 32'd2);
    req = 2'b01;
    drive_bytes(1, 5, 1'b0, 8'h50, sent, tf, tl);
    chk("to_sent", 32'(sent), 32'd5);
    cnt = 0;
    while (grant[1] && cnt < 200) begin
      @(negedge clk_a);
      cnt++;
    end
    chk("to_stall_cycles", 32'(cnt), 32'd64);
    chk("to_err_timeout", 32'(err_timeout), 32'd1);
    chk("to_pkt_unchanged", 32'(pkt_count), 32'(pc));
    wait_grant(g);
    chk("to_next_grant", 32'(g), 32'd1);
    req = 2'b00;
    drive_bytes(0, 1, 1'b1, 8'h77, sent, tf, tl);
    chk("to_next_pkt", 32'(pkt_count), 32'(pc + 16'd1));
    err_clr = 1'b1;
    @(negedge clk_a);
    err_clr = 1'b0;
    chk("err_timeout_clr", 32'(err_timeout), 32'd0);
    wait_idle();

    // Enable gating
    enable = 1'b0;
    req = 2'b01;
    repeat (20) @(negedge clk_a);
    chk("en_off_grant", 32'(grant), 32'd0);
    chk("en_off_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_grant(g);
    chk("en_on_grant", 32'(g), 32'd1);
    req = 2'b00;
    pc = pkt_count;
    drive_bytes(0, 3, 1'b0, 8'h10, sent, tf, tl);
    enable = 1'b0;
    req = 2'b11;
    drive_bytes(0, 7, 1'b1, 8'h13, sent, tf, tl);
    chk("en_drop_sent", 32'(sent), 32'd7);
    chk("en_drop_pkt", 32'(pkt_count), 32'(pc + 16'd1));
    repeat (30) @(negedge clk_a);
    chk("en_hold_grant", 32'(grant), 32'd0);
    chk("en_hold_busy", 32'(busy), 32'd0);
    req = 2'b00;
    enable = 1'b1;

    // Reset on byte 20 of a packet
    req = 2'b01;
    wait_grant(g);
    req = 2'b00;
    drive_bytes(0, 19, 1'b0, 8'h20, sent, tf, tl);
    chk("rst_mid_sent", 32'(sent), 32'd19);
    src_valid[0] = 1'b1;
    src_data[0 +: W] = 8'h33;
    rst_n = 1'b0;
    @(negedge clk_a);
    chk("rst_mid_grant", 32'(grant), 32'd0);
    chk("rst_mid_valid", 32'(data_valid_a), 32'd0);
    chk("rst_mid_pkt", 32'(pkt_count), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    src_valid = '0;
    rst_n = 1'b1;
    req = 2'b11;
    wait_grant(g);
    chk("rst_prio_grant", 32'(g), 32'd1);
    req = 2'b00;
    drive_bytes(0, 1, 1'b1, 8'h99, sent, tf, tl);
    chk("rst_after_pkt", 32'(pkt_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
